// File: rtl/cc_timer_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// | Module   : cc_timer_pkg                                                 |
// | Brief    : Shared constants and types for the cc_* timer/counter blocks |
// | Revision : 1.0 - initial release                                        |
// ---------------------------------------------------------------------------
package cc_timer_pkg;

  localparam logic STATE_IDLE = 1'b0;
  localparam logic STATE_RUN  = 1'b1;

  localparam int DEFAULT_WIDTH    = 8;
  localparam int DEFAULT_PRESCALE = 50;

  typedef enum logic {
    ST_IDLE = STATE_IDLE,
    ST_RUN  = STATE_RUN
  } state_t;

endpackage : cc_timer_pkg
`default_nettype wire

// File: rtl/cc_match_counter_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// | Module   : cc_match_counter_if                                          |
// | Brief    : Load handshake, control and status bundle of the match       |
// |            counter. master = controlling agent, slave = counter.        |
// | Revision : 1.0 - initial release                                        |
// ---------------------------------------------------------------------------
interface cc_match_counter_if
  import cc_timer_pkg::*;
#(
  parameter int NUMBER_DATAWIDTH = DEFAULT_WIDTH
) ();

  logic                        CC_MATCH_COUNTER_loadValid_In;
  logic                        CC_MATCH_COUNTER_loadReady_Out;
  logic [NUMBER_DATAWIDTH-1:0] CC_MATCH_COUNTER_loadData_InBUS;
  logic                        CC_MATCH_COUNTER_start_In;
  logic                        CC_MATCH_COUNTER_stop_In;
  logic                        CC_MATCH_COUNTER_periodic_In;
  logic [NUMBER_DATAWIDTH-1:0] CC_MATCH_COUNTER_count_OutBUS;
  logic                        CC_MATCH_COUNTER_match_OutLow;
  logic                        CC_MATCH_COUNTER_busy_Out;

  modport master (
    output CC_MATCH_COUNTER_loadValid_In,
    input  CC_MATCH_COUNTER_loadReady_Out,
    output CC_MATCH_COUNTER_loadData_InBUS,
    output CC_MATCH_COUNTER_start_In,
    output CC_MATCH_COUNTER_stop_In,
    output CC_MATCH_COUNTER_periodic_In,
    input  CC_MATCH_COUNTER_count_OutBUS,
    input  CC_MATCH_COUNTER_match_OutLow,
    input  CC_MATCH_COUNTER_busy_Out
  );

  modport slave (
    input  CC_MATCH_COUNTER_loadValid_In,
    output CC_MATCH_COUNTER_loadReady_Out,
    input  CC_MATCH_COUNTER_loadData_InBUS,
    input  CC_MATCH_COUNTER_start_In,
    input  CC_MATCH_COUNTER_stop_In,
    input  CC_MATCH_COUNTER_periodic_In,
    output CC_MATCH_COUNTER_count_OutBUS,
    output CC_MATCH_COUNTER_match_OutLow,
    output CC_MATCH_COUNTER_busy_Out
  );

endinterface : cc_match_counter_if
`default_nettype wire

// File: rtl/cc_match_detect.sv
`default_nettype none
// ---------------------------------------------------------------------------
// | Module   : cc_match_detect                                              |
// | Brief    : Combinational count-vs-target equality, active-low flag      |
// | Revision : 1.0 - initial release                                        |
// ---------------------------------------------------------------------------
module cc_match_detect
  import cc_timer_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  wire logic [WIDTH-1:0] count_i,
  input  wire logic [WIDTH-1:0] target_i,
  output logic                  match_n_o
);

  // Low when the running count has reached the target.
  assign match_n_o = (count_i != target_i);

endmodule : cc_match_detect
`default_nettype wire

// File: rtl/cc_match_counter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// | Module   : cc_match_counter                                             |
// | Brief    : Loadable up-counter that emits a one-cycle active-low pulse  |
// |            when the count reaches the target; periodic or one-shot.     |
// |            Optional prescaler: CC_MATCH_COUNTER_PRESCALE_EN             |
// | Revision : 1.0 - initial release                                        |
// ---------------------------------------------------------------------------
module cc_match_counter
  import cc_timer_pkg::*;
#(
  parameter int NUMBER_DATAWIDTH = DEFAULT_WIDTH,
  parameter int PRESCALE_DIVIDER = DEFAULT_PRESCALE
) (
  input  wire logic         CC_MATCH_COUNTER_CLOCK_50,
  input  wire logic         CC_MATCH_COUNTER_RESET_InHigh,
  cc_match_counter_if.slave bus
);

  localparam int W = NUMBER_DATAWIDTH;

  // A divider of zero would never produce a count step.
  if (PRESCALE_DIVIDER < 1) begin : g_bad_prescale
    $error("cc_match_counter: PRESCALE_DIVIDER must be >= 1");
  end

  state_t         state_q, state_d;
  logic [W-1:0]   target_q, target_d;
  logic [W-1:0]   count_q, count_d;
  logic           match_n_q, match_n_d;
  logic           busy_q, busy_d;
  logic           ready_q, ready_d;
  logic           match_n;
  logic           step;

  cc_match_detect #(
    .WIDTH (W)
  ) u_match_detect (
    .count_i   (count_q),
    .target_i  (target_q),
    .match_n_o (match_n)
  );

`ifdef CC_MATCH_COUNTER_PRESCALE_EN
  localparam int PW = (PRESCALE_DIVIDER > 1) ? $clog2(PRESCALE_DIVIDER) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE_DIVIDER - 1);

  logic [PW-1:0] presc_q;

  // Prescaler is held at zero in IDLE so every RUN entry starts a full interval.
  always_ff @(posedge CC_MATCH_COUNTER_CLOCK_50 or posedge CC_MATCH_COUNTER_RESET_InHigh) begin
    if (CC_MATCH_COUNTER_RESET_InHigh) begin
      presc_q <= '0;
    end else if (state_q == ST_IDLE || presc_q == PRESC_LAST) begin
      presc_q <= '0;
    end else begin
      presc_q <= presc_q + 1'b1;
    end
  end

  assign step = (presc_q == PRESC_LAST);
`else
  assign step = 1'b1;
`endif

  // Next-state, target/count update and match pulse generation.
  always_comb begin
    state_d   = state_q;
    target_d  = target_q;
    count_d   = count_q;
    match_n_d = 1'b1;
    case (state_q)
      ST_IDLE: begin
        if (bus.CC_MATCH_COUNTER_loadValid_In) begin
          target_d = bus.CC_MATCH_COUNTER_loadData_InBUS;
        end
        // Start qualifies against the target already held, not one loading now.
        if (bus.CC_MATCH_COUNTER_start_In && !bus.CC_MATCH_COUNTER_stop_In &&
            (target_q != '0)) begin
          state_d = ST_RUN;
          count_d = '0;
        end
      end
      ST_RUN: begin
        if (step && !match_n) begin
          // A match step always pulses; a concurrent stop only cancels the restart.
          match_n_d = 1'b0;
          if (bus.CC_MATCH_COUNTER_periodic_In && !bus.CC_MATCH_COUNTER_stop_In) begin
            count_d = '0;
          end else begin
            state_d = ST_IDLE;
          end
        end else if (bus.CC_MATCH_COUNTER_stop_In) begin
          state_d = ST_IDLE;
        end else if (step) begin
          count_d = count_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    busy_d  = (state_d == ST_RUN);
    ready_d = (state_d == ST_IDLE);
  end

  // State and registered outputs.
  always_ff @(posedge CC_MATCH_COUNTER_CLOCK_50 or posedge CC_MATCH_COUNTER_RESET_InHigh) begin
    if (CC_MATCH_COUNTER_RESET_InHigh) begin
      state_q   <= ST_IDLE;
      target_q  <= '0;
      count_q   <= '0;
      match_n_q <= 1'b1;
      busy_q    <= 1'b0;
      ready_q   <= 1'b1;
    end else begin
      state_q   <= state_d;
      target_q  <= target_d;
      count_q   <= count_d;
      match_n_q <= match_n_d;
      busy_q    <= busy_d;
      ready_q   <= ready_d;
    end
  end

  assign bus.CC_MATCH_COUNTER_loadReady_Out = ready_q;
  assign bus.CC_MATCH_COUNTER_count_OutBUS  = count_q;
  assign bus.CC_MATCH_COUNTER_match_OutLow  = match_n_q;
  assign bus.CC_MATCH_COUNTER_busy_Out      = busy_q;

endmodule : cc_match_counter
`default_nettype wire

// File: tb/tb_cc_match_counter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// | Module   : tb_cc_match_counter                                          |
// | Brief    : Directed self-checking bench for cc_match_counter            |
// |            (prescaler scenario when CC_MATCH_COUNTER_PRESCALE_EN)       |
// | Revision : 1.0 - initial release                                        |
// ---------------------------------------------------------------------------
module tb_cc_match_counter;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  cc_match_counter_if #(.NUMBER_DATAWIDTH(8)) bus ();

  cc_match_counter #(
    .NUMBER_DATAWIDTH (8),
    .PRESCALE_DIVIDER (4)
  ) u_dut (
    .CC_MATCH_COUNTER_CLOCK_50     (clk),
    .CC_MATCH_COUNTER_RESET_InHigh (rst),
    .bus                           (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic load(input logic [7:0] val);
    bus.CC_MATCH_COUNTER_loadValid_In   = 1'b1;
    bus.CC_MATCH_COUNTER_loadData_InBUS = val;
    cyc(1);
    bus.CC_MATCH_COUNTER_loadValid_In   = 1'b0;
  endtask

  task automatic start_run();
    bus.CC_MATCH_COUNTER_start_In = 1'b1;
    cyc(1);
    bus.CC_MATCH_COUNTER_start_In = 1'b0;
  endtask

  task automatic stop_run();
    bus.CC_MATCH_COUNTER_stop_In = 1'b1;
    cyc(1);
    bus.CC_MATCH_COUNTER_stop_In = 1'b0;
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    bus.CC_MATCH_COUNTER_loadValid_In   = 1'b0;
    bus.CC_MATCH_COUNTER_loadData_InBUS = '0;
    bus.CC_MATCH_COUNTER_start_In       = 1'b0;
    bus.CC_MATCH_COUNTER_stop_In        = 1'b0;
    bus.CC_MATCH_COUNTER_periodic_In    = 1'b0;
    cyc(1);
    check_val("rst_count", bus.CC_MATCH_COUNTER_count_OutBUS, 0);
    check_val("rst_match", bus.CC_MATCH_COUNTER_match_OutLow, 1);
    check_val("rst_busy",  bus.CC_MATCH_COUNTER_busy_Out, 0);
    check_val("rst_ready", bus.CC_MATCH_COUNTER_loadReady_Out, 1);
    rst = 1'b0;

`ifdef CC_MATCH_COUNTER_PRESCALE_EN
    // Divider 4, target 2, periodic: 3 steps of 4 clocks = 12-clock period.
    bus.CC_MATCH_COUNTER_periodic_In = 1'b1;
    load(8'd2);
    start_run();
    check_val("ps_entry_count", bus.CC_MATCH_COUNTER_count_OutBUS, 0);
    for (int k = 1; k <= 25; k++) begin
      cyc(1);
      check_val("ps_count", bus.CC_MATCH_COUNTER_count_OutBUS, (k % 12) / 4);
      check_val("ps_match", bus.CC_MATCH_COUNTER_match_OutLow, (k > 0 && k % 12 == 0) ? 0 : 1);
    end
    stop_run();
    check_val("ps_stop_busy", bus.CC_MATCH_COUNTER_busy_Out, 0);
`else
    // Periodic target 5: counts 0..5, pulse one cycle after 5, every 6 clocks.
    bus.CC_MATCH_COUNTER_periodic_In = 1'b1;
    load(8'd5);
    start_run();
    check_val("p5_entry_count", bus.CC_MATCH_COUNTER_count_OutBUS, 0);
    check_val("p5_entry_busy",  bus.CC_MATCH_COUNTER_busy_Out, 1);
    check_val("p5_entry_ready", bus.CC_MATCH_COUNTER_loadReady_Out, 0);
    for (int k = 1; k <= 13; k++) begin
      cyc(1);
      check_val("p5_count", bus.CC_MATCH_COUNTER_count_OutBUS, k % 6);
      check_val("p5_match", bus.CC_MATCH_COUNTER_match_OutLow, (k % 6 == 0) ? 0 : 1);
    end
    stop_run();
    check_val("p5_stop_busy",  bus.CC_MATCH_COUNTER_busy_Out, 0);
    check_val("p5_stop_count", bus.CC_MATCH_COUNTER_count_OutBUS, 1);

    // One-shot target 3.
    bus.CC_MATCH_COUNTER_periodic_In = 1'b0;
    load(8'd3);
    start_run();
    cyc(3);
    check_val("os_count3", bus.CC_MATCH_COUNTER_count_OutBUS, 3);
    check_val("os_nomatch", bus.CC_MATCH_COUNTER_match_OutLow, 1);
    cyc(1);
    check_val("os_match",  bus.CC_MATCH_COUNTER_match_OutLow, 0);
    check_val("os_busy",   bus.CC_MATCH_COUNTER_busy_Out, 0);
    check_val("os_ready",  bus.CC_MATCH_COUNTER_loadReady_Out, 1);
    check_val("os_hold",   bus.CC_MATCH_COUNTER_count_OutBUS, 3);
    cyc(1);
    check_val("os_match_end", bus.CC_MATCH_COUNTER_match_OutLow, 1);
    check_val("os_hold2",     bus.CC_MATCH_COUNTER_count_OutBUS, 3);

    // Stop on the match step: pulse still emitted, then IDLE despite periodic.
    bus.CC_MATCH_COUNTER_periodic_In = 1'b1;
    start_run();
    cyc(3);
    bus.CC_MATCH_COUNTER_stop_In = 1'b1;
    cyc(1);
    bus.CC_MATCH_COUNTER_stop_In = 1'b0;
    check_val("sm_match", bus.CC_MATCH_COUNTER_match_OutLow, 0);
    check_val("sm_busy",  bus.CC_MATCH_COUNTER_busy_Out, 0);
    check_val("sm_count", bus.CC_MATCH_COUNTER_count_OutBUS, 3);
    cyc(1);
    check_val("sm_match_end", bus.CC_MATCH_COUNTER_match_OutLow, 1);

    // Start with target 0 is ignored; load+start uses the old target.
    pulse_reset();
    check_val("z_ready", bus.CC_MATCH_COUNTER_loadReady_Out, 1);
    bus.CC_MATCH_COUNTER_start_In = 1'b1;
    cyc(2);
    check_val("z_busy",  bus.CC_MATCH_COUNTER_busy_Out, 0);
    check_val("z_match", bus.CC_MATCH_COUNTER_match_OutLow, 1);
    check_val("z_count", bus.CC_MATCH_COUNTER_count_OutBUS, 0);
    bus.CC_MATCH_COUNTER_loadValid_In   = 1'b1;
    bus.CC_MATCH_COUNTER_loadData_InBUS = 8'd3;
    cyc(1);
    bus.CC_MATCH_COUNTER_loadValid_In   = 1'b0;
    check_val("ls_old_target", bus.CC_MATCH_COUNTER_busy_Out, 0);
    cyc(1);
    bus.CC_MATCH_COUNTER_start_In = 1'b0;
    check_val("ls_new_target", bus.CC_MATCH_COUNTER_busy_Out, 1);
    stop_run();
    check_val("ls_stop", bus.CC_MATCH_COUNTER_busy_Out, 0);
    bus.CC_MATCH_COUNTER_start_In = 1'b1;
    bus.CC_MATCH_COUNTER_stop_In  = 1'b1;
    cyc(1);
    bus.CC_MATCH_COUNTER_start_In = 1'b0;
    bus.CC_MATCH_COUNTER_stop_In  = 1'b0;
    check_val("ss_idle", bus.CC_MATCH_COUNTER_busy_Out, 0);

    // Target 7, stop at count 4; then a load during RUN is refused.
    load(8'd7);
    start_run();
    cyc(4);
    check_val("st_count4", bus.CC_MATCH_COUNTER_count_OutBUS, 4);
    stop_run();
    check_val("st_busy",  bus.CC_MATCH_COUNTER_busy_Out, 0);
    check_val("st_count", bus.CC_MATCH_COUNTER_count_OutBUS, 4);
    check_val("st_match", bus.CC_MATCH_COUNTER_match_OutLow, 1);
    start_run();
    check_val("rl_ready", bus.CC_MATCH_COUNTER_loadReady_Out, 0);
    bus.CC_MATCH_COUNTER_loadValid_In   = 1'b1;
    bus.CC_MATCH_COUNTER_loadData_InBUS = 8'd2;
    cyc(3);
    check_val("rl_count3", bus.CC_MATCH_COUNTER_count_OutBUS, 3);
    check_val("rl_nomatch", bus.CC_MATCH_COUNTER_match_OutLow, 1);
    cyc(4);
    check_val("rl_count7", bus.CC_MATCH_COUNTER_count_OutBUS, 7);
    cyc(1);
    check_val("rl_match", bus.CC_MATCH_COUNTER_match_OutLow, 0);
    check_val("rl_wrap",  bus.CC_MATCH_COUNTER_count_OutBUS, 0);
    bus.CC_MATCH_COUNTER_loadValid_In = 1'b0;
    stop_run();
    check_val("rl_idle",  bus.CC_MATCH_COUNTER_busy_Out, 0);

    // Target all-ones, then asynchronous reset mid-RUN.
    pulse_reset();
    load(8'd255);
    start_run();
    cyc(255);
    check_val("ff_count", bus.CC_MATCH_COUNTER_count_OutBUS, 255);
    check_val("ff_nomatch", bus.CC_MATCH_COUNTER_match_OutLow, 1);
    cyc(1);
    check_val("ff_match", bus.CC_MATCH_COUNTER_match_OutLow, 0);
    check_val("ff_wrap",  bus.CC_MATCH_COUNTER_count_OutBUS, 0);
    check_val("ff_busy",  bus.CC_MATCH_COUNTER_busy_Out, 1);
    cyc(100);
    check_val("ar_count100", bus.CC_MATCH_COUNTER_count_OutBUS, 100);
    #2 rst = 1'b1;
    #1;
    check_val("ar_count", bus.CC_MATCH_COUNTER_count_OutBUS, 0);
    check_val("ar_match", bus.CC_MATCH_COUNTER_match_OutLow, 1);
    check_val("ar_busy",  bus.CC_MATCH_COUNTER_busy_Out, 0);
    check_val("ar_ready", bus.CC_MATCH_COUNTER_loadReady_Out, 1);
    cyc(1);
    rst = 1'b0;
    cyc(2);
    check_val("ar_stays_idle", bus.CC_MATCH_COUNTER_busy_Out, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_cc_match_counter
`default_nettype wire
